vend_controller: RTL and testbench
==================================

# vend_controller

Parametrised vending controller that sits downstream of the coin detector and replaces the fixed 25-cent dispenser state machine. It accumulates credit from one-cycle coin pulses, vends at a configurable price, returns change as paced dime/nickel ejector pulses, and supports a customer cancel/refund. All arithmetic is in cents; every value is a multiple of 5.

## Interface
- PRICE, default 35: item price in cents; multiple of 5, range 5..250.
- CREDIT_W, default 8: credit register width in bits; must hold PRICE+20.
- GAP, default 4: cycles between successive change pulses, ≥2.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- nickelDetected  input  1  one-cycle pulse, 5 cents inserted.
- dimeDetected  input  1  one-cycle pulse, 10 cents inserted.
- quarterDetected  input  1  one-cycle pulse, 25 cents inserted.
- cancel  input  1  level; refund request, sampled only in COLLECT.
- dispense  output  1  one-cycle vend pulse.
- dimeOut  output  1  one-cycle pulse, eject one dime.
- nickelOut  output  1  one-cycle pulse, eject one nickel.
- credit  output  CREDIT_W  current credit in cents.
- busy  output  1  high while in PAYOUT.
- fault  output  1  sticky error flag; cleared only by reset.

## Operation
- Clock and reset: one clock domain; reset is asynchronous and active-high. While reset is high: state=COLLECT, credit=0, gap counter=0, and dispense, dimeOut, nickelOut, busy and fault are all 0.
- Coin value per cycle: quarter=25, else dime=10, else nickel=5, else 0. Priority is quarter > dime > nickel. If more than one coin input is high in the same cycle, only the highest-priority coin counts and fault is set.
- COLLECT:
  - Let sum = credit + coin value.
  - If sum ≥ PRICE: assert dispense for one cycle and set credit = sum − PRICE. Go to PAYOUT if that remainder is >0, otherwise stay in COLLECT.
  - Else if cancel=1 and sum>0: set credit = sum and go to PAYOUT. A coin and cancel in the same cycle are both honoured.
  - Else: set credit = sum.
- PAYOUT:
  - The gap counter counts 0..GAP−1.
  - When the counter is 0: if credit ≥ 10, pulse dimeOut and subtract 10; else if credit = 5, pulse nickelOut and subtract 5.
  - When credit reaches 0 after a pulse and no coin arrives that cycle, return to COLLECT.
  - Coins arriving in PAYOUT are added to credit in the same cycle as any subtraction, so they are refunded. Price checking and cancel are ignored in PAYOUT.
- Saturation: if an addition would exceed 2^CREDIT_W−1, credit clamps to 2^CREDIT_W−1 and fault is set.
- busy = (state==PAYOUT), registered.
- dispense, dimeOut and nickelOut are never high in the same cycle.

## Timing
- All outputs are registered. dispense is high in the cycle after the clk edge that samples the completing coin pulse.
- The first change pulse is asserted 1 cycle after dispense; on the cancel path it is asserted 1 cycle after entry to PAYOUT.
- Subsequent change pulses are spaced exactly GAP cycles apart, rising edge to rising edge.
- credit updates on the same edge as the associated pulse.
- busy rises on the same edge as dispense (change owed) or on the cancel-acceptance edge. busy falls on the edge after the final change pulse.
- Worst-case payout for remainder R: ceil(R/10) pulses, with a nickel only as the last pulse.
- Reset mid-payout: any pulse in flight is cut off asynchronously, and the remaining change is discarded.

## Test plan
- PRICE=35, GAP=4: quarter, then dime 3 cycles later → one dispense pulse 1 cycle after the dime; credit 0; busy never high; no change pulses.
- Quarter, then quarter → dispense, then credit=15. dimeOut 1 cycle after dispense leaves credit=5. nickelOut 4 cycles later leaves credit=0. busy drops the next cycle.
- Nickel ×3 (credit=15), then cancel → no dispense. dimeOut leaves credit=5, then nickelOut 4 cycles later leaves credit=0. State returns to COLLECT.
- Nickel inserted in PAYOUT between two change pulses → credit rises by 5 and one extra nickelOut follows. No dispense occurs even if credit ≥35.
- dimeDetected and nickelDetected high in the same cycle in COLLECT → credit +10 only and fault=1. fault stays 1 through a later normal vend until reset.
- Reset asserted asynchronously mid-clock during PAYOUT with credit=15 → all outputs and credit go to 0 before the next edge. No further change pulses after reset is released.

Source files
------------

// File: rtl/vend_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : vend_controller_if
//  Brief    : Coin-detector / ejector bundle for the vending controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface vend_controller_if #(
    parameter int CREDIT_W = 8
);
    logic                nickelDetected;
    logic                dimeDetected;
    logic                quarterDetected;
    logic                cancel;
    logic                dispense;
    logic                dimeOut;
    logic                nickelOut;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                fault;

    modport master (
        output nickelDetected, dimeDetected, quarterDetected, cancel,
        input  dispense, dimeOut, nickelOut, credit, busy, fault
    );

    modport slave (
        input  nickelDetected, dimeDetected, quarterDetected, cancel,
        output dispense, dimeOut, nickelOut, credit, busy, fault
    );
endinterface
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vend_controller
//  Brief    : Credit accumulator, parametrised-price vend and paced change payout.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
    parameter int PRICE    = 35,
    parameter int CREDIT_W = 8,
    parameter int GAP      = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    vend_controller_if.slave  bus
);
    localparam int                  c_CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CREDIT_W-1:0] c_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] c_SAT   = {CREDIT_W{1'b1}};

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PAYOUT  = 1'b1
    } state_t;

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [c_CNT_W-1:0]  r_gap_cnt;
    logic                r_dispense;
    logic                r_dime_out;
    logic                r_nickel_out;
    logic                r_busy;
    logic                r_fault;

    logic [CREDIT_W-1:0] w_coin_val;
    logic                w_multi;
    logic                w_dime_pulse;
    logic                w_nickel_pulse;
    logic [CREDIT_W-1:0] w_base;
    logic [CREDIT_W:0]   w_sum;
    logic                w_sat;
    logic [CREDIT_W-1:0] w_new;

    // Change is taken out before the incoming coin is added, so a coin
    // arriving on a pulse cycle is simply refunded later.
    always_comb begin
        w_coin_val     = '0;
        w_dime_pulse   = 1'b0;
        w_nickel_pulse = 1'b0;
        w_base         = r_credit;
        if (bus.quarterDetected)      w_coin_val = CREDIT_W'(25);
        else if (bus.dimeDetected)    w_coin_val = CREDIT_W'(10);
        else if (bus.nickelDetected)  w_coin_val = CREDIT_W'(5);
        w_multi = (bus.quarterDetected & bus.dimeDetected)
                | (bus.quarterDetected & bus.nickelDetected)
                | (bus.dimeDetected    & bus.nickelDetected);
        if (r_state == PAYOUT && r_gap_cnt == '0) begin
            if (r_credit >= CREDIT_W'(10)) begin
                w_dime_pulse = 1'b1;
                w_base       = r_credit - CREDIT_W'(10);
            end else if (r_credit == CREDIT_W'(5)) begin
                w_nickel_pulse = 1'b1;
                w_base         = '0;
            end
        end
        w_sum = {1'b0, w_base} + {1'b0, w_coin_val};
        w_sat = w_sum[CREDIT_W];
        w_new = w_sat ? c_SAT : w_sum[CREDIT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= COLLECT;
            r_credit     <= '0;
            r_gap_cnt    <= '0;
            r_dispense   <= 1'b0;
            r_dime_out   <= 1'b0;
            r_nickel_out <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_dispense   <= 1'b0;
            r_dime_out   <= 1'b0;
            r_nickel_out <= 1'b0;
            if (w_multi || w_sat) r_fault <= 1'b1;
            case (r_state)
                COLLECT: begin
                    r_gap_cnt <= '0;
                    if (w_new >= c_PRICE) begin
                        r_dispense <= 1'b1;
                        r_credit   <= w_new - c_PRICE;
                        if (w_new != c_PRICE) begin
                            r_state <= PAYOUT;
                            r_busy  <= 1'b1;
                        end
                    end else if (bus.cancel && w_new != '0) begin
                        r_credit <= w_new;
                        r_state  <= PAYOUT;
                        r_busy   <= 1'b1;
                    end else begin
                        r_credit <= w_new;
                    end
                end
                PAYOUT: begin
                    // Leave one cycle after the last pulse so busy spans it.
                    if (r_credit == '0 && w_coin_val == '0) begin
                        r_state   <= COLLECT;
                        r_busy    <= 1'b0;
                        r_gap_cnt <= '0;
                    end else begin
                        r_credit     <= w_new;
                        r_dime_out   <= w_dime_pulse;
                        r_nickel_out <= w_nickel_pulse;
                        r_gap_cnt    <= (r_gap_cnt == c_CNT_W'(GAP - 1)) ? '0
                                      : r_gap_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign bus.dispense  = r_dispense;
    assign bus.dimeOut   = r_dime_out;
    assign bus.nickelOut = r_nickel_out;
    assign bus.credit    = r_credit;
    assign bus.busy      = r_busy;
    assign bus.fault     = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_controller
//  Brief    : Randomised and directed bench for vend_controller with a cents model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;
    localparam int PRICE    = 35;
    localparam int CREDIT_W = 8;
    localparam int GAP      = 4;
    localparam int MAXC     = (1 << CREDIT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vend_controller_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_controller #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W),
        .GAP      (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_pulse = -1;

    int m_credit;
    bit m_paying;
    int m_tick;
    bit m_fault, m_disp, m_dime, m_nick;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_paying = 0; m_tick = 0;
        m_fault = 0; m_disp = 0; m_dime = 0; m_nick = 0;
    endtask

    // Cents-level reference: what one clock edge must do to credit and pulses.
    task automatic model_step(input bit n, input bit d, input bit q, input bit c);
        int cv, sum;
        cv = q ? 25 : d ? 10 : n ? 5 : 0;
        m_disp = 0; m_dime = 0; m_nick = 0;
        if (int'(n) + int'(d) + int'(q) > 1) m_fault = 1;
        if (!m_paying) begin
            sum = m_credit + cv;
            if (sum > MAXC) begin sum = MAXC; m_fault = 1; end
            if (sum >= PRICE) begin
                m_disp   = 1;
                m_credit = sum - PRICE;
                if (m_credit > 0) begin m_paying = 1; m_tick = 0; end
            end else if (c && sum > 0) begin
                m_credit = sum; m_paying = 1; m_tick = 0;
            end else begin
                m_credit = sum;
            end
        end else if (m_credit == 0 && cv == 0) begin
            m_paying = 0;
        end else begin
            if (m_tick == 0) begin
                if (m_credit >= 10) begin m_dime = 1; m_credit -= 10; end
                else if (m_credit == 5) begin m_nick = 1; m_credit -= 5; end
            end
            sum = m_credit + cv;
            if (sum > MAXC) begin sum = MAXC; m_fault = 1; end
            m_credit = sum;
            m_tick   = (m_tick + 1) % GAP;
        end
    endtask

    task automatic compare();
        check("dispense",  int'(bus.dispense),  int'(m_disp));
        check("dimeOut",   int'(bus.dimeOut),   int'(m_dime));
        check("nickelOut", int'(bus.nickelOut), int'(m_nick));
        check("credit",    int'(bus.credit),    m_credit);
        check("busy",      int'(bus.busy),      int'(m_paying));
        check("fault",     int'(bus.fault),     int'(m_fault));
        check("exclusive", int'(bus.dispense) + int'(bus.dimeOut) + int'(bus.nickelOut) <= 1, 1);
        if (bus.dimeOut || bus.nickelOut) begin
            if (last_pulse >= 0) check("pulse_gap", cyc - last_pulse, GAP);
            last_pulse = cyc;
        end
        if (!bus.busy) last_pulse = -1;
    endtask

    task automatic step(input bit n, input bit d, input bit q, input bit c);
        bus.nickelDetected  = n;
        bus.dimeDetected    = d;
        bus.quarterDetected = q;
        bus.cancel          = c;
        @(posedge clk);
        model_step(n, d, q, c);
        cyc++;
        #1 compare();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0);
    endtask

    // Asserted mid-cycle: outputs must clear before the next edge.
    task automatic do_reset();
        bus.nickelDetected = 0; bus.dimeDetected = 0;
        bus.quarterDetected = 0; bus.cancel = 0;
        #1 reset = 1'b1;
        #1;
        check("rst_credit",   int'(bus.credit),    0);
        check("rst_busy",     int'(bus.busy),      0);
        check("rst_dispense", int'(bus.dispense),  0);
        check("rst_dimeOut",  int'(bus.dimeOut),   0);
        check("rst_nickel",   int'(bus.nickelOut), 0);
        check("rst_fault",    int'(bus.fault),     0);
        model_reset();
        last_pulse = -1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        bit n, d, q, c;
        int r;
        reset = 1'b1;
        bus.nickelDetected = 0; bus.dimeDetected = 0;
        bus.quarterDetected = 0; bus.cancel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_credit", int'(bus.credit), 0);
        check("init_busy",   int'(bus.busy),   0);
        check("init_fault",  int'(bus.fault),  0);
        reset = 1'b0;

        // Exact-price vend: quarter then dime.
        step(0, 0, 1, 0); idle(2); step(0, 1, 0, 0);
        check("s1_dispense", int'(bus.dispense), 1);
        check("s1_credit",   int'(bus.credit),   0);
        check("s1_busy",     int'(bus.busy),     0);
        idle(2);

        // 50 cents: vend, then dime + nickel change.
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        check("s2_dispense", int'(bus.dispense), 1);
        check("s2_credit",   int'(bus.credit),   15);
        check("s2_busy",     int'(bus.busy),     1);
        step(0, 0, 0, 0);
        check("s2_dime",     int'(bus.dimeOut),  1);
        check("s2_credit5",  int'(bus.credit),   5);
        idle(3); step(0, 0, 0, 0);
        check("s2_nickel",   int'(bus.nickelOut), 1);
        check("s2_credit0",  int'(bus.credit),   0);
        step(0, 0, 0, 0);
        check("s2_busy_off", int'(bus.busy),     0);
        idle(2);

        // Three nickels then cancel.
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
        check("s3_credit",   int'(bus.credit), 15);
        step(0, 0, 0, 1);
        check("s3_busy",     int'(bus.busy),     1);
        check("s3_nodisp",   int'(bus.dispense), 0);
        step(0, 0, 0, 0);
        check("s3_dime",     int'(bus.dimeOut),  1);
        idle(3); step(0, 0, 0, 0);
        check("s3_nickel",   int'(bus.nickelOut), 1);
        step(0, 0, 0, 0);
        check("s3_busy_off", int'(bus.busy),     0);
        idle(2);

        // Nickel injected during payout of 20 cents.
        step(0, 0, 1, 0); step(1, 0, 0, 0); step(0, 0, 1, 0);
        check("s4_credit",   int'(bus.credit), 20);
        step(0, 0, 0, 0);
        check("s4_dime1",    int'(bus.dimeOut), 1);
        step(1, 0, 0, 0);
        check("s4_credit15", int'(bus.credit), 15);
        idle(2); step(0, 0, 0, 0);
        check("s4_dime2",    int'(bus.dimeOut), 1);
        idle(3); step(0, 0, 0, 0);
        check("s4_nickel",   int'(bus.nickelOut), 1);
        idle(3);

        // Dime and nickel together: only the dime counts, fault sticks.
        step(1, 1, 0, 0);
        check("s5_credit",   int'(bus.credit), 10);
        check("s5_fault",    int'(bus.fault),  1);
        step(0, 0, 1, 0);
        check("s5_dispense", int'(bus.dispense), 1);
        check("s5_fault2",   int'(bus.fault),  1);
        idle(2);

        // Reset mid-payout with 15 cents owed.
        do_reset();
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        check("s6_credit",   int'(bus.credit), 15);
        do_reset();
        idle(10);
        check("s6_idle_credit", int'(bus.credit), 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            n = 0; d = 0; q = 0;
            if (r < 7)       n = 1;
            else if (r < 14) d = 1;
            else if (r < 20) q = 1;
            else if (r < 21) begin n = 1; d = 1; q = 1'($urandom_range(0, 1)); end
            c = ($urandom_range(0, 19) == 0);
            step(n, d, q, c);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
